cpu_run_ctrl: RTL
=================

# cpu_run_ctrl

Synthesizable load/run/dump controller that replaces the hand-written poke-RAM, run-N-cycles, print-registers sequence used to exercise the CPU core. It sits beside `cpu` and does four things in order:
- holds the core in reset while streaming a program image into RAM;
- releases the core for a programmable number of cycles;
- freezes the core;
- streams the register file back out for checking.

It is parametrised in data width, address width and register count, and adds a cycle-count readback.

## Interface
Parameters:
- DATA_W, 8, RAM word / register width
- ADDR_W, 8, RAM address width; depth = 2^ADDR_W
- NREGS, 2, registers dumped (R0..R(NREGS-1))
- CNT_W, 16, run cycle counter width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low
- start  input  1  one-cycle pulse; begins a LOAD; ignored unless state is IDLE or DONE
- run_cycles  input  CNT_W  cycles to run; latched on accepted start
- ld_valid / ld_ready  input / output  1  program byte handshake
- ld_data  input  DATA_W  program word
- ld_last  input  1  final program word
- mem_we  output  1  RAM write strobe
- mem_addr  output  ADDR_W  RAM address
- mem_wdata  output  DATA_W  RAM write data
- cpu_rst_n  output  1  core reset, active-low
- cpu_en  output  1  core clock enable
- pc_in  input  ADDR_W  core PC
- reg_sel  output  $clog2(NREGS)  register read select
- reg_rdata  input  DATA_W  combinational register read data
- dump_valid / dump_ready  output / input  1  dump handshake
- dump_data  output  DATA_W  dumped register value
- dump_last  output  1  marks the final dump word
- busy, done, overflow  output  1  status
- run_count  output  CNT_W  cycles actually executed in the last RUN
- break_addr  input  ADDR_W  breakpoint address; present only with CPU_RUN_CTRL_BREAK_EN
- brk_hit  output  1  breakpoint flag; present only with CPU_RUN_CTRL_BREAK_EN

## Operation
- States: IDLE → LOAD → RUN → DUMP → DONE. DONE → LOAD on start.
- **IDLE**
  - cpu_rst_n=0, cpu_en=0, ld_ready=0.
- **LOAD**
  - ld_ready=1, cpu_rst_n=0.
  - Each handshake writes ld_data at the address counter (starts at 0), then increments it.
  - Leave on a beat with ld_last, or after the 2^ADDR_W-th beat. In the second case set overflow=1 and ignore further beats (ld_ready=0).
- **RUN**
  - cpu_rst_n=1, cpu_en=1 for exactly run_cycles cycles. run_count increments per enabled cycle.
  - run_cycles=0: RUN lasts zero cycles (go to DUMP) but cpu_rst_n still pulses high for no enabled edge.
- **DUMP**
  - cpu_en=0; cpu_rst_n stays 1 so core state holds.
  - reg_sel starts at 0. dump_data = reg_rdata (combinational), dump_valid=1, dump_last=(reg_sel==NREGS-1).
  - reg_sel advances on handshake. After the last handshake, go to DONE.
- **DONE**
  - done=1 and outputs hold until the next start.
  - overflow, run_count and brk_hit are cleared on an accepted start.
- busy=1 in LOAD/RUN/DUMP.

## Timing
- Reset values: all outputs 0 (cpu_rst_n=0, mem_* 0, run_count 0); state IDLE.
- Async reset mid-operation: immediate return to IDLE and core back in reset. A partially written RAM is not restored.
- start→LOAD: one cycle; ld_ready rises the cycle after start.
- mem_we/mem_addr/mem_wdata are registered: valid the cycle after the ld handshake, mem_we a one-cycle pulse per beat.
- LOAD→RUN: the cycle after the last mem_we pulse. The first enabled core edge is the first RUN cycle.
- RUN→DUMP: the cycle after the run_cycles-th enabled cycle. dump_valid is high in the first DUMP cycle.
- dump_valid stays high while dump_ready=0; dump_data is stable while stalled.
- start asserted while busy: ignored; run_cycles is not re-latched.

## Configuration
- CPU_RUN_CTRL_BREAK_EN defined:
  - Adds break_addr and brk_hit.
  - In RUN, an enabled cycle with pc_in==break_addr is the last one: brk_hit=1, go to DUMP next cycle, run_count includes that cycle.
  - Checked only on enabled cycles.
- Undefined: the ports are absent; RUN always lasts run_cycles.

## Test plan
- Load 4 words 0x00 with run_cycles=20 → mem_we pulses at addr 0..3 with data 0x00; RUN 20 cycles; dump R0 then R1 with dump_last on R1; run_count=20; done=1.
- Load 1 word with run_cycles=0 → no enabled cycles; dump shows reset register values; run_count=0.
- ADDR_W=2, 6 beats without ld_last → 4 writes (addr 0..3), overflow=1, ld_ready=0 after the 4th beat, then RUN proceeds.
- Hold dump_ready=0 for 5 cycles in DUMP → dump_valid=1 and dump_data=R0 stable; reg_sel unchanged.
- Assert reset low mid-RUN (cycle 7 of 20) → cpu_rst_n=0, cpu_en=0, busy=0 the same cycle; a new start performs a full sequence.
- With BREAK_EN: program of 8 NOPs, break_addr=3, run_cycles=100 → brk_hit=1, run_count equals the cycles taken to reach PC=3, DUMP follows.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Load/run/dump sequencer for the CPU core: streams a program into RAM, runs the core for a
// programmed cycle count, then streams the register file out. Breakpoint option: CPU_RUN_CTRL_BREAK_EN.
module cpu_run_ctrl #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned NREGS  = 2,
   parameter int unsigned CNT_W  = 16,
   localparam int unsigned SEL_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  run_cycles,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_rst_n,
   output logic              cpu_en,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [SEL_W-1:0]  reg_sel,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_last,
`ifdef CPU_RUN_CTRL_BREAK_EN
   input  logic [ADDR_W-1:0] break_addr,
   output logic              brk_hit,
`endif
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [CNT_W-1:0]  run_count
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP, S_DONE} state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  run_lat;
   logic [CNT_W-1:0]  run_next;
   logic [ADDR_W-1:0] addr_cnt;
   logic              load_fin;
   logic              accept;
   logic              ld_fire;
   logic              dump_fire;
   logic              brk_now;
   logic              run_last;

   assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
   assign ld_fire   = ld_valid && ld_ready;
   assign dump_fire = dump_valid && dump_ready;
   assign run_next  = run_count + 1'b1;

`ifdef CPU_RUN_CTRL_BREAK_EN
   logic brk_flag;
   assign brk_now = cpu_en && (pc_in == break_addr);
   assign brk_hit = brk_flag;
`else
   logic unused_pc;
   assign brk_now   = 1'b0;
   assign unused_pc = ^pc_in;
`endif

   assign run_last = cpu_en && ((run_next == run_lat) || brk_now);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE, S_DONE: if (start) state_nx = S_LOAD;
         // load_fin holds LOAD for one extra cycle so the final mem_we pulse lands before RUN
         S_LOAD:         if (load_fin) state_nx = S_RUN;
         S_RUN:          if (!cpu_en || run_last) state_nx = S_DUMP;
         S_DUMP:         if (dump_fire && dump_last) state_nx = S_DONE;
         default:        state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      ld_ready   = 1'b0;
      cpu_rst_n  = 1'b0;
      cpu_en     = 1'b0;
      dump_valid = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         S_LOAD: begin
            busy     = 1'b1;
            ld_ready = !load_fin;
         end
         S_RUN: begin
            busy      = 1'b1;
            cpu_rst_n = 1'b1;
            // a zero cycle budget gives one RUN cycle with the core out of reset but not enabled
            cpu_en    = (run_count != run_lat);
         end
         S_DUMP: begin
            busy       = 1'b1;
            cpu_rst_n  = 1'b1;
            dump_valid = 1'b1;
         end
         S_DONE: begin
            cpu_rst_n = 1'b1;
            done      = 1'b1;
         end
         default: ;
      endcase
   end

   assign dump_data = dump_valid ? reg_rdata : '0;
   assign dump_last = dump_valid && (reg_sel == SEL_W'(NREGS - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_lat   <= '0;
         run_count <= '0;
         addr_cnt  <= '0;
         load_fin  <= 1'b0;
         overflow  <= 1'b0;
         reg_sel   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef CPU_RUN_CTRL_BREAK_EN
         brk_flag  <= 1'b0;
`endif
      end else begin
         mem_we <= 1'b0;
         if (accept) begin
            run_lat   <= run_cycles;
            run_count <= '0;
            addr_cnt  <= '0;
            load_fin  <= 1'b0;
            overflow  <= 1'b0;
            reg_sel   <= '0;
`ifdef CPU_RUN_CTRL_BREAK_EN
            brk_flag  <= 1'b0;
`endif
         end
         if (ld_fire) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr_cnt;
            mem_wdata <= ld_data;
            addr_cnt  <= addr_cnt + 1'b1;
            if (ld_last) begin
               load_fin <= 1'b1;
            end else if (addr_cnt == '1) begin
               load_fin <= 1'b1;
               overflow <= 1'b1;
            end
         end
         if (cpu_en) begin
            run_count <= run_next;
         end
`ifdef CPU_RUN_CTRL_BREAK_EN
         if (brk_now) begin
            brk_flag <= 1'b1;
         end
`endif
         if (dump_fire && !dump_last) begin
            reg_sel <= reg_sel + 1'b1;
         end
      end
   end

endmodule
